// File: rtl/tone_synth_if.sv
// tone_synth_if: note request, live controls and audio/status outputs of tone_synth
interface tone_synth_if #(
  parameter int DIV_W = 22,
  parameter int DUR_W = 24,
  parameter int AUD_W = 16,
  parameter int VOL_W = 3
);
  logic note_valid;
  logic note_ready;
  logic [DIV_W-1:0] note_div;
  logic [DUR_W-1:0] note_dur;
  logic [VOL_W-1:0] volume;
  logic mute_left;
  logic mute_right;
  logic abort;
  logic signed [AUD_W-1:0] audio_left;
  logic signed [AUD_W-1:0] audio_right;
  logic busy;
  logic done;
  modport master (
    output note_valid, note_div, note_dur, volume, mute_left, mute_right, abort,
    input  note_ready, audio_left, audio_right, busy, done
  );
  modport slave (
    input  note_valid, note_div, note_dur, volume, mute_left, mute_right, abort,
    output note_ready, audio_left, audio_right, busy, done
  );
endinterface

// File: rtl/tone_synth.sv
// tone_synth: square-wave note player with per-note duration, trailing gap, volume and live mute
module tone_synth #(
  parameter int DIV_W   = 22,
  parameter int DUR_W   = 24,
  parameter int AUD_W   = 16,
  parameter int VOL_W   = 3,
  parameter int GAP_CYC = 4
) (
  input logic clk,
  input logic rst,
  tone_synth_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  localparam int GAP_W = GAP_CYC > 0 ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [AUD_W-1:0] FULL = {1'b0, {(AUD_W-1){1'b1}}};
  state_t r_state, w_state;
  logic [DIV_W-1:0] r_div, w_div, r_cnt, w_cnt;
  logic [DUR_W-1:0] r_dur, w_dur;
  logic [GAP_W-1:0] r_gap, w_gap;
  logic [VOL_W-1:0] r_vol, w_vol;
  logic r_phase, w_phase, r_done, w_done, w_accept;
  logic [AUD_W-1:0] w_amp, w_sig;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_dur   <= '0;
      r_gap   <= '0;
      r_vol   <= '0;
      r_phase <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_cnt   <= w_cnt;
      r_dur   <= w_dur;
      r_gap   <= w_gap;
      r_vol   <= w_vol;
      r_phase <= w_phase;
      r_done  <= w_done;
    end
  end
  // abort only matters outside IDLE, but in IDLE it still suppresses acceptance
  always_comb begin
    w_state  = r_state;
    w_div    = r_div;
    w_cnt    = r_cnt;
    w_dur    = r_dur;
    w_gap    = r_gap;
    w_vol    = r_vol;
    w_phase  = r_phase;
    w_done   = 1'b0;
    w_accept = r_state == IDLE && bus.note_valid && !bus.abort;
    if (w_accept) begin
      w_state = PLAY;
      w_div   = bus.note_div;
      w_vol   = bus.volume;
      w_cnt   = '0;
      w_phase = 1'b0;
      w_dur   = bus.note_dur == '0 ? DUR_W'(1) : bus.note_dur;
    end else if (r_state != IDLE && bus.abort) begin
      w_state = IDLE;
      w_cnt   = '0;
      w_phase = 1'b0;
      w_dur   = '0;
      w_gap   = '0;
    end else if (r_state == PLAY) begin
      w_cnt   = r_cnt == r_div ? '0 : r_cnt + 1'b1;
      w_phase = r_phase ^ (r_cnt == r_div);
      w_dur   = r_dur - 1'b1;
      if (r_dur == DUR_W'(1)) begin
        w_cnt   = '0;
        w_phase = 1'b0;
        w_gap   = GAP_W'(GAP_CYC);
        w_done  = GAP_CYC == 0;
        if (GAP_CYC == 0) w_state = IDLE;
        else w_state = GAP;
      end
    end else if (r_state == GAP) begin
      w_gap = r_gap - 1'b1;
      if (r_gap == GAP_W'(1)) begin
        w_state = IDLE;
        w_done  = 1'b1;
      end
    end
  end
  // ~volume equals (2^VOL_W-1-volume), the attenuation shift
  assign w_amp = r_vol == '0 ? '0 : FULL >> ~r_vol;
  assign w_sig = (r_state == PLAY && r_div != '0) ? (r_phase ? -w_amp : w_amp) : '0;
  assign bus.audio_left  = bus.mute_left  ? '0 : w_sig;
  assign bus.audio_right = bus.mute_right ? '0 : w_sig;
  assign bus.note_ready  = r_state == IDLE;
  assign bus.busy        = r_state != IDLE;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: scoreboard bench; per-cycle expectations queued at note acceptance, compared each negedge
module tb_tone_synth;
  localparam int DIV_W = 22;
  localparam int DUR_W = 24;
  localparam int AUD_W = 16;
  localparam int VOL_W = 3;
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] cyc;
    logic [15:0] l;
    logic [15:0] r;
    logic busy;
    logic done;
    logic ready;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  exp_t q[$];
  exp_t e;
  tone_synth_if #(.DIV_W(DIV_W), .DUR_W(DUR_W), .AUD_W(AUD_W), .VOL_W(VOL_W)) bus();
  tone_synth #(.DIV_W(DIV_W), .DUR_W(DUR_W), .AUD_W(AUD_W), .VOL_W(VOL_W), .GAP_CYC(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("n%0d_c%0d_left", e.id, e.cyc), bus.audio_left, e.l);
      chk($sformatf("n%0d_c%0d_right", e.id, e.cyc), bus.audio_right, e.r);
      chk($sformatf("n%0d_c%0d_busy", e.id, e.cyc), 16'(bus.busy), 16'(e.busy));
      chk($sformatf("n%0d_c%0d_done", e.id, e.cyc), 16'(bus.done), 16'(e.done));
      chk($sformatf("n%0d_c%0d_ready", e.id, e.cyc), 16'(bus.note_ready), 16'(e.ready));
    end
  end
  function automatic int amp(int v);
    return v == 0 ? 0 : 32767 >> (7 - v);
  endfunction
  task automatic push_note(int id, int div, int dur, int vol, int cut, int ml_from, int ml_to);
    int d = dur == 0 ? 1 : dur;
    int n = cut > 0 ? cut : d;
    exp_t x;
    x.id = 8'(id);
    for (int k = 1; k <= n; k++) begin
      int ph = ((k - 1) / (div + 1)) % 2;
      int s = div == 0 ? 0 : (ph != 0 ? -amp(vol) : amp(vol));
      x.cyc = 16'(k);
      x.r = 16'(s);
      x.l = (k >= ml_from && k < ml_to) ? 16'h0 : 16'(s);
      x.busy = 1'b1;
      x.done = 1'b0;
      x.ready = 1'b0;
      q.push_back(x);
    end
    if (cut == 0) begin
      for (int k = 1; k <= 4; k++) begin
        x.cyc = 16'(d + k);
        x.l = 16'h0;
        x.r = 16'h0;
        x.busy = 1'b1;
        x.done = 1'b0;
        x.ready = 1'b0;
        q.push_back(x);
      end
    end
    x.cyc = 16'(n + (cut == 0 ? 4 : 0) + 1);
    x.l = 16'h0;
    x.r = 16'h0;
    x.busy = 1'b0;
    x.done = cut == 0;
    x.ready = 1'b1;
    q.push_back(x);
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((q.size() > 0 || !bus.note_ready) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_wait", 16'(t < 500), 16'h1);
  endtask
  task automatic send(int id, int div, int dur, int vol, int cut, int ml_from, int ml_to);
    wait_idle();
    bus.note_valid = 1'b1;
    bus.note_div = DIV_W'(div);
    bus.note_dur = DUR_W'(dur);
    bus.volume = VOL_W'(vol);
    @(posedge clk);
    #1;
    bus.note_valid = 1'b0;
    push_note(id, div, dur, vol, cut, ml_from, ml_to);
  endtask
  initial begin
    bus.note_valid = 1'b0;
    bus.note_div = '0;
    bus.note_dur = '0;
    bus.volume = '0;
    bus.mute_left = 1'b0;
    bus.mute_right = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_left", bus.audio_left, 16'h0);
    chk("rst_right", bus.audio_right, 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_ready", 16'(bus.note_ready), 16'h1);
    send(1, 3, 20, 7, 0, 0, 0);
    send(2, 1, 0, 6, 0, 0, 0);
    send(3, 0, 10, 5, 0, 0, 0);
    send(4, 3, 20, 7, 0, 6, 12);
    repeat (5) @(posedge clk);
    #1;
    bus.mute_left = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.mute_left = 1'b0;
    send(5, 2, 30, 5, 5, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    bus.note_valid = 1'b1;
    bus.note_div = DIV_W'(4);
    bus.note_dur = DUR_W'(6);
    bus.volume = VOL_W'(3);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    bus.note_valid = 1'b0;
    push_note(6, 4, 6, 3, 0, 0, 0);
    wait_idle();
    bus.abort = 1'b1;
    bus.note_valid = 1'b1;
    bus.note_div = DIV_W'(5);
    bus.note_dur = DUR_W'(3);
    bus.volume = VOL_W'(7);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", 16'(bus.busy), 16'h0);
    chk("abort_idle_ready", 16'(bus.note_ready), 16'h1);
    @(posedge clk);
    #1;
    bus.note_valid = 1'b0;
    push_note(7, 5, 3, 7, 0, 0, 0);
    send(8, 3, 20, 7, 4, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(9, 1, 6, 7, 0, 0, 0);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
